spi_target: RTL and testbench
=============================

// Module: spi_target
// PURPOSE
// - SPI mode 0 target (slave). Receives bytes from an external SPI master and returns bytes to it.
// - MSB first on both mosi and miso.
// - Samples sclk/cs_n/mosi through synchronisers into the system clock domain.
// - One-byte tx and rx holding registers with valid/ready handshakes towards a memory-mapped wrapper.
// PARAMETERS
// - SYNC_STAGES  2     flops per input synchroniser (sclk, cs_n, mosi); minimum 2.
// - IDLE_BYTE    8'hff byte shifted out when the tx holding register is empty at load.
// PORTS
// - clk             in   1  system clock
// - rst_n           in   1  asynchronous active-low reset
// - sclk            in   1  SPI clock from master (async)
// - cs_n            in   1  SPI chip select, active low (async)
// - mosi            in   1  SPI data in (async)
// - miso            out  1  SPI data out
// - miso_oe         out  1  miso output enable; high only while selected
// - tx_data         in   8  byte to queue for transmission
// - tx_load         in   1  write tx_data into tx holding; honoured only when tx_ready=1
// - tx_ready        out  1  tx holding register empty
// - tx_underrun     out  1  1-cycle pulse: IDLE_BYTE substituted at a byte load
// - rx_data         out  8  last complete received byte
// - rx_valid        out  1  rx_data holds an unacknowledged byte
// - rx_ack          in   1  consume rx_data; clears rx_valid
// - rx_overrun      out  1  sticky: a byte arrived while rx_valid=1 (SPI_TARGET_OVERRUN_EN)
// - rx_overrun_clr  in   1  clears rx_overrun
// - busy            out  1  synchronised cs_n asserted
// BEHAVIOUR
// - Reset values:
//   - miso=1, miso_oe=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, rx_overrun=0, busy=0.
//   - Internal: bit counter 0, shift registers 0, FSM IDLE.
// - Edge detection:
//   - sclk_s, cs_n_s, mosi_s are the SYNC_STAGES-synchronised inputs.
//   - Edges are detected against a registered copy of each synchronised signal.
//   - Requirement: sclk high and low phases each >= SYNC_STAGES+2 clk cycles.
//   - Requirement: mosi stable across the synchronised rising edge.
// - FSM IDLE:
//   - busy=0, miso_oe=0, miso=1.
//   - cs_n_s falling edge -> ACTIVE.
//   - In the same cycle: load the tx shift register (byte load, below), bit counter=0, miso_oe=1, miso=shift[7].
// - FSM ACTIVE:
//   - busy=1.
//   - sclk_s rising edge: shift mosi_s into rx shift LSB; bit counter += 1 (3-bit, wraps 7->0).
//     - On the 8th rising edge (counter 7->0): rx_data <= completed byte, rx_valid <= 1. Both are visible the cycle after the edge is detected.
//   - sclk_s falling edge:
//     - If counter != 0: tx shift <<= 1; miso = new shift[7].
//     - If counter == 0 (byte boundary): perform a byte load; miso = new shift[7].
//   - cs_n_s rising edge -> IDLE.
//     - Any partial rx byte is discarded: no rx_valid, counter=0.
//     - A partially sent tx byte is lost; it is not reloaded.
// - Byte load:
//   - If tx holding is full: shift <= holding, tx_ready <= 1.
//   - If tx holding is empty: shift <= IDLE_BYTE, tx_underrun pulses for 1 cycle.
// - tx handshake: tx_load with tx_ready=1 writes holding, tx_ready <= 0 next cycle.
//   - tx_load with tx_ready=0 is ignored.
//   - tx_load coinciding with a byte load of a full holding register: the load consumes the old byte, the new byte is written, tx_ready stays 0.
// - rx handshake: rx_ack clears rx_valid next cycle.
//   - rx_ack coinciding with byte completion: the new byte wins, rx_valid stays 1, no overrun.
// - An sclk edge while in IDLE (cs_n high) is ignored.
// - rst_n assertion mid-transfer returns every output to its reset value immediately (asynchronous).
// CONFIGURATION
// - SPI_TARGET_OVERRUN_EN defined:
//   - rx_overrun sets when a byte completes while rx_valid=1 and rx_ack=0.
//   - rx_data is still overwritten with the new byte.
//   - rx_overrun clears on rx_overrun_clr; set wins if both occur in the same cycle.
// - SPI_TARGET_OVERRUN_EN undefined:
//   - rx_overrun is tied to 0 and rx_overrun_clr is ignored.
//   - Overwrite is silent.
// TESTING
// - Basic echo: tx_load 8'ha5, then cs_n low, master sends 8'h3c.
//   -> miso bits 1,0,1,0,0,1,0,1 on rising edges.
//   -> rx_data=8'h3c, rx_valid=1 one cycle after the 8th edge; tx_ready=1.
// - Underrun: nothing queued, select, 1 byte.
//   -> miso shifts 8'hff; tx_underrun pulses once at select.
// - Back-to-back: queue 8'h01, select; queue 8'h02 during byte 1; 2 bytes (8'h11, 8'h22).
//   -> miso carries 8'h01 then 8'h02.
//   -> two rx_valid events with data 8'h11, 8'h22 (ack between).
// - Abort: cs_n high after 5 sclk rising edges.
//   -> no rx_valid; busy=0; miso_oe=0.
//   -> the next full byte is received correctly.
// - Overrun (EN defined): 2 bytes 8'haa, 8'h55 with no rx_ack.
//   -> rx_data=8'h55, rx_overrun=1; rx_overrun_clr -> 0.
//   - With EN undefined: rx_overrun stays 0.
// - Reset: rst_n low mid-byte.
//   -> all outputs take their reset values with no clk edge.
//   -> after release, a fresh select transfers correctly.

Source files
------------

// File: rtl/spi_target.sv
// spi_target: SPI mode 0 target (CPOL=0, CPHA=0), MSB first on mosi and miso.
// sclk, cs_n and mosi are synchronised into the clk domain and edge-detected there.
// One-byte tx and rx holding registers with valid/ready handshakes.
// Optional feature macro: SPI_TARGET_OVERRUN_EN (sticky rx_overrun flag).
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hff
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  input  logic       rx_overrun_clr,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_n_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_q;
  logic                   r_cs_n_q;
  logic [0:0]             r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic [7:0]             r_tx_hold;
  logic                   r_tx_full;
  logic                   r_tx_underrun;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rx_overrun;

  logic       w_sclk_s;
  logic       w_cs_n_s;
  logic       w_mosi_s;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_active;
  logic       w_select;
  logic       w_rise_act;
  logic       w_fall_act;
  logic       w_byte_load;
  logic       w_byte_done;
  logic       w_tx_accept;
  logic [7:0] w_rx_next;

  // Input synchronisers; cs_n resets high so reset release never looks like a select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_n_sync <= '1;
      r_mosi_sync <= '0;
      r_sclk_q    <= 1'b0;
      r_cs_n_q    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_q    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_n_q    <= r_cs_n_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n_s    = r_cs_n_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_q;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_q;
  assign w_cs_fall   = ~w_cs_n_s & r_cs_n_q;
  assign w_cs_rise   = w_cs_n_s & ~r_cs_n_q;
  assign w_active    = (r_state == ST_ACTIVE);
  // Deselect takes priority over any sclk edge seen in the same cycle.
  assign w_select    = ~w_active & w_cs_fall;
  assign w_rise_act  = w_active & ~w_cs_rise & w_sclk_rise;
  assign w_fall_act  = w_active & ~w_cs_rise & w_sclk_fall;
  assign w_byte_load = w_select | (w_fall_act & (r_bit_cnt == 3'd0));
  assign w_byte_done = w_rise_act & (r_bit_cnt == 3'd7);
  assign w_rx_next   = {r_rx_shift[6:0], w_mosi_s};
  // A load landing on the same cycle as a byte load frees the slot it refills.
  assign w_tx_accept = tx_load & (~r_tx_full | w_byte_load);

  // FSM, bit counter and the two shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
    end else begin
      if (w_select) begin
        r_state   <= ST_ACTIVE;
        r_bit_cnt <= 3'd0;
      end else if (w_active && w_cs_rise) begin
        r_state    <= ST_IDLE;
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
      end else begin
        if (w_rise_act) begin
          r_rx_shift <= w_rx_next;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        if (w_fall_act && (r_bit_cnt != 3'd0)) begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
      end
      if (w_byte_load) begin
        r_tx_shift <= r_tx_full ? r_tx_hold : IDLE_BYTE;
      end
    end
  end

  // tx holding register, its full flag and the underrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_hold     <= 8'h00;
      r_tx_full     <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= w_byte_load & ~r_tx_full;
      if (w_tx_accept) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_byte_load) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  // rx holding register; a completing byte beats a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_byte_done) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_TARGET_OVERRUN_EN
  // Sticky overrun flag; setting wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_overrun <= 1'b0;
    end else if (w_byte_done && r_rx_valid && !rx_ack) begin
      r_rx_overrun <= 1'b1;
    end else if (rx_overrun_clr) begin
      r_rx_overrun <= 1'b0;
    end
  end
`else
  assign r_rx_overrun = 1'b0;
  logic w_unused_clr;
  assign w_unused_clr = rx_overrun_clr;
`endif

  assign miso        = w_active ? r_tx_shift[7] : 1'b1;
  assign miso_oe     = w_active;
  assign busy        = w_active;
  assign tx_ready    = ~r_tx_full;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: bench for spi_target; a byte-level model of the target is
// compared against the DUT outputs every cycle the outputs are settled.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       rx_overrun_clr = 1'b0;
  logic       busy;

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hff)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun),
    .rx_overrun_clr(rx_overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit         m_settled = 1'b0;
  bit         m_hold_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  bit         m_rx_valid = 1'b0;
  logic [7:0] m_rx_data = 8'h00;
  bit         m_overrun = 1'b0;
  bit         m_busy = 1'b0;
  int         m_under = 0;
  logic [7:0] exp_tx[$];

  int checks = 0;
  int errors = 0;
  int under_seen = 0;

  logic [7:0] mosi_bytes[4];
  logic [7:0] miso_got[4];
  logic [7:0] txq_bytes[4];
  bit         txq_en[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Count underrun pulses as cycles high; a pulse longer than one cycle shows up as extra counts.
  always @(posedge clk) if (rst_n && tx_underrun) under_seen++;

  // Per-cycle compare against the model whenever the outputs have settled.
  always @(posedge clk) begin
    #1;
    if (rst_n && m_settled) begin
      chk("busy", busy, m_busy);
      chk("miso_oe", miso_oe, m_busy);
      chk("tx_ready", tx_ready, !m_hold_full);
      chk("rx_valid", rx_valid, m_rx_valid);
      chk("rx_data", rx_data, m_rx_data);
      chk("rx_overrun", rx_overrun, m_overrun);
      chk("underrun_count", under_seen, m_under);
      if (!m_busy) chk("miso_idle", miso, 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A byte load takes the queued byte or substitutes the idle byte.
  task automatic m_byte_load();
    if (m_hold_full) exp_tx.push_back(m_hold);
    else begin
      exp_tx.push_back(8'hff);
      m_under++;
    end
    m_hold_full = 1'b0;
  endtask

  task automatic m_rx_done(input logic [7:0] b);
`ifdef SPI_TARGET_OVERRUN_EN
    if (m_rx_valid) m_overrun = 1'b1;
`endif
    m_rx_valid = 1'b1;
    m_rx_data  = b;
  endtask

  task automatic do_txload(input logic [7:0] d);
    m_settled = 1'b0;
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    if (!m_hold_full) begin
      m_hold = d;
      m_hold_full = 1'b1;
    end
    tick(1);
    m_settled = 1'b1;
  endtask

  task automatic do_ack();
    m_settled = 1'b0;
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_rx_valid = 1'b0;
    tick(1);
    m_settled = 1'b1;
  endtask

  task automatic do_clr();
    m_settled = 1'b0;
    @(negedge clk);
    rx_overrun_clr = 1'b1;
    @(negedge clk);
    rx_overrun_clr = 1'b0;
`ifdef SPI_TARGET_OVERRUN_EN
    m_overrun = 1'b0;
`endif
    tick(1);
    m_settled = 1'b1;
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < 4; k++) begin
      txq_en[k] = 1'b0;
      txq_bytes[k] = 8'h00;
      miso_got[k] = 8'h00;
    end
  endtask

  // One SPI master transaction: select, nbytes (or abort after abort_bits rising edges), deselect.
  task automatic spi_xfer(input int nbytes, input int abort_bits, input bit ack_each);
    bit stop;
    stop = 1'b0;
    m_settled = 1'b0;
    cs_n = 1'b0;
    mosi = mosi_bytes[0][7];
    tick(6);
    m_busy = 1'b1;
    m_byte_load();
    m_settled = 1'b1;
    tick(2);
    for (int b = 0; b < nbytes && !stop; b++) begin
      for (int i = 0; i < 8 && !stop; i++) begin
        miso_got[b][7-i] = miso;
        m_settled = 1'b0;
        sclk = 1'b1;
        tick(6);
        if (i == 7) m_rx_done(mosi_bytes[b]);
        m_settled = 1'b1;
        tick(2);
        if (i == 7) begin
          chk("miso_byte", miso_got[b], exp_tx.pop_front());
          if (ack_each) do_ack();
        end
        if (txq_en[b] && i == 2) do_txload(txq_bytes[b]);
        if ((b * 8 + i + 1 == abort_bits) || (b == nbytes - 1 && i == 7)) stop = 1'b1;
        else begin
          m_settled = 1'b0;
          sclk = 1'b0;
          mosi = (i == 7) ? mosi_bytes[b+1][7] : mosi_bytes[b][6-i];
          tick(6);
          if (i == 7) m_byte_load();
          m_settled = 1'b1;
          tick(2);
        end
      end
    end
    // Deselect with sclk still high; the later falling edge arrives while idle.
    m_settled = 1'b0;
    cs_n = 1'b1;
    tick(6);
    m_busy = 1'b0;
    exp_tx.delete();
    m_settled = 1'b1;
    tick(2);
    m_settled = 1'b0;
    sclk = 1'b0;
    tick(6);
    m_settled = 1'b1;
    tick(4);
    $display("xfer bytes=%0d abort=%0d mosi0=%02h miso0=%02h rx_data=%02h", nbytes, abort_bits,
             mosi_bytes[0], miso_got[0], rx_data);
  endtask

  initial begin
    int n;
    int ab;
    int u0;
    clear_cfg();
    for (int k = 0; k < 4; k++) mosi_bytes[k] = 8'h00;

    // Reset state
    tick(2);
    #1;
    chk("rst_miso", miso, 1'b1);
    chk("rst_miso_oe", miso_oe, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    m_settled = 1'b1;
    tick(2);

    // Basic echo
    do_txload(8'ha5);
    mosi_bytes[0] = 8'h3c;
    spi_xfer(1, 0, 1'b0);
    chk("echo_miso", miso_got[0], 8'ha5);
    chk("echo_rx_data", rx_data, 8'h3c);
    chk("echo_rx_valid", rx_valid, 1'b1);
    chk("echo_tx_ready", tx_ready, 1'b1);
    do_ack();

    // Underrun
    u0 = under_seen;
    mosi_bytes[0] = 8'h00;
    spi_xfer(1, 0, 1'b0);
    chk("underrun_miso", miso_got[0], 8'hff);
    chk("underrun_pulses", under_seen - u0, 1);
    do_ack();

    // Back-to-back
    clear_cfg();
    do_txload(8'h01);
    mosi_bytes[0] = 8'h11;
    mosi_bytes[1] = 8'h22;
    txq_en[0] = 1'b1;
    txq_bytes[0] = 8'h02;
    spi_xfer(2, 0, 1'b1);
    chk("b2b_miso0", miso_got[0], 8'h01);
    chk("b2b_miso1", miso_got[1], 8'h02);
    chk("b2b_rx_data", rx_data, 8'h22);
    clear_cfg();

    // Abort after 5 rising edges, then a full byte
    mosi_bytes[0] = 8'hff;
    spi_xfer(1, 5, 1'b0);
    chk("abort_rx_valid", rx_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_miso_oe", miso_oe, 1'b0);
    mosi_bytes[0] = 8'h5a;
    spi_xfer(1, 0, 1'b0);
    chk("after_abort_rx", rx_data, 8'h5a);
    do_ack();

    // Overrun
    mosi_bytes[0] = 8'haa;
    mosi_bytes[1] = 8'h55;
    spi_xfer(2, 0, 1'b0);
    chk("ovr_rx_data", rx_data, 8'h55);
`ifdef SPI_TARGET_OVERRUN_EN
    chk("ovr_flag", rx_overrun, 1'b1);
`else
    chk("ovr_flag_off", rx_overrun, 1'b0);
`endif
    do_clr();
    chk("ovr_cleared", rx_overrun, 1'b0);
    do_ack();

    // Asynchronous reset mid-byte
    do_txload(8'hc3);
    m_settled = 1'b0;
    cs_n = 1'b0;
    tick(8);
    sclk = 1'b1;
    tick(8);
    sclk = 1'b0;
    tick(8);
    sclk = 1'b1;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_miso", miso, 1'b1);
    chk("arst_miso_oe", miso_oe, 1'b0);
    chk("arst_tx_ready", tx_ready, 1'b1);
    chk("arst_underrun", tx_underrun, 1'b0);
    chk("arst_rx_data", rx_data, 8'h00);
    chk("arst_rx_valid", rx_valid, 1'b0);
    chk("arst_overrun", rx_overrun, 1'b0);
    chk("arst_busy", busy, 1'b0);
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    m_hold_full = 1'b0;
    m_rx_valid = 1'b0;
    m_rx_data = 8'h00;
    m_overrun = 1'b0;
    m_busy = 1'b0;
    exp_tx.delete();
    tick(3);
    rst_n = 1'b1;
    tick(4);
    m_settled = 1'b1;
    tick(2);
    do_txload(8'h69);
    mosi_bytes[0] = 8'h96;
    spi_xfer(1, 0, 1'b0);
    chk("post_rst_miso", miso_got[0], 8'h69);
    chk("post_rst_rx", rx_data, 8'h96);

    // Randomised transfers
    for (int t = 0; t < 30; t++) begin
      clear_cfg();
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        mosi_bytes[k] = 8'($urandom);
        txq_en[k] = 1'($urandom);
        txq_bytes[k] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) do_txload(8'($urandom));
      if ($urandom_range(0, 3) == 0) do_txload(8'($urandom));
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, n * 8 - 1) : 0;
      spi_xfer(n, ab, 1'($urandom));
      if ($urandom_range(0, 2) == 0) do_ack();
      if ($urandom_range(0, 3) == 0) do_clr();
    end

    m_settled = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
